// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single memory slave; the losing master is stalled via its HREADY and replayed.
// Optional round-robin arbitration is enabled with `define AHB_ARB_ROUND_ROBIN_EN (fixed priority, master 0 first, otherwise).
module ahb_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic [ADDR_W-1:0] m0_HADDR,
    input  logic [1:0]        m0_HTRANS,
    input  logic              m0_HWRITE,
    input  logic [2:0]        m0_HSIZE,
    input  logic [31:0]       m0_HWDATA,
    output logic              m0_HREADY,
    output logic [31:0]       m0_HRDATA,

    input  logic [ADDR_W-1:0] m1_HADDR,
    input  logic [1:0]        m1_HTRANS,
    input  logic              m1_HWRITE,
    input  logic [2:0]        m1_HSIZE,
    input  logic [31:0]       m1_HWDATA,
    output logic              m1_HREADY,
    output logic [31:0]       m1_HRDATA,

    output logic              S_HSEL,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [1:0]        S_HTRANS,
    output logic              S_HWRITE,
    output logic [2:0]        S_HSIZE,
    output logic [31:0]       S_HWDATA,
    output logic              S_HREADY,
    input  logic              S_HREADYOUT,
    input  logic [31:0]       S_HRDATA
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic              pend_0, pend_1;
    logic [ADDR_W-1:0] pend_addr_0, pend_addr_1;
    logic              pend_write_0, pend_write_1;
    logic [2:0]        pend_size_0, pend_size_1;

    logic              dp_valid;
    logic              dp_owner;

    logic [ADDR_W-1:0] last_addr;
    logic              last_write;
    logic [2:0]        last_size;

    logic              live_0, live_1;
    logic              req_0, req_1;
    logic              grant;
    logic              issue;
    logic              cap_0, cap_1;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_write;
    logic [2:0]        sel_size;

    // HTRANS[0] only separates NONSEQ from SEQ / IDLE from BUSY, which this block treats alike.
    logic unused_trans_lsb;
    assign unused_trans_lsb = m0_HTRANS[0] ^ m1_HTRANS[0];

    // A master is held off while its transfer sits in the pending slot, or while its own data phase is stalled.
    assign m0_HREADY = ~pend_0 & ~(dp_valid & ~dp_owner & ~S_HREADYOUT);
    assign m1_HREADY = ~pend_1 & ~(dp_valid &  dp_owner & ~S_HREADYOUT);

    assign live_0 = m0_HREADY & m0_HTRANS[1];
    assign live_1 = m1_HREADY & m1_HTRANS[1];
    assign req_0  = pend_0 | live_0;
    assign req_1  = pend_1 | live_1;
    assign issue  = S_HREADYOUT & (req_0 | req_1);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        grant = 1'b0;
        if (req_0 && req_1) begin
            // A buffered transfer always beats a fresh one; otherwise alternate.
            if (pend_0 && !pend_1)
                grant = 1'b0;
            else if (pend_1 && !pend_0)
                grant = 1'b1;
            else
                grant = ~last_grant;
        end else begin
            grant = req_1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_grant <= 1'b1;
        else if (issue)
            last_grant <= grant;
    end
`else
    always_comb begin
        grant = 1'b0;
        if (!req_0 && req_1)
            grant = 1'b1;
    end
`endif

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = 3'b000;
        if (grant) begin
            sel_addr  = pend_1 ? pend_addr_1  : m1_HADDR;
            sel_write = pend_1 ? pend_write_1 : m1_HWRITE;
            sel_size  = pend_1 ? pend_size_1  : m1_HSIZE;
        end else begin
            sel_addr  = pend_0 ? pend_addr_0  : m0_HADDR;
            sel_write = pend_0 ? pend_write_0 : m0_HWRITE;
            sel_size  = pend_0 ? pend_size_0  : m0_HSIZE;
        end
    end

    assign S_HSEL   = issue;
    assign S_HTRANS = issue ? TRANS_NONSEQ : TRANS_IDLE;
    assign S_HADDR  = issue ? sel_addr  : last_addr;
    assign S_HWRITE = issue ? sel_write : last_write;
    assign S_HSIZE  = issue ? sel_size  : last_size;
    assign S_HWDATA = dp_owner ? m1_HWDATA : m0_HWDATA;
    assign S_HREADY = S_HREADYOUT;

    assign m0_HRDATA = S_HRDATA;
    assign m1_HRDATA = S_HRDATA;

    assign cap_0 = live_0 & ~(issue & ~grant);
    assign cap_1 = live_1 & ~(issue &  grant);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_0       <= 1'b0;
            pend_addr_0  <= '0;
            pend_write_0 <= 1'b0;
            pend_size_0  <= 3'b000;
        end else if (cap_0) begin
            pend_0       <= 1'b1;
            pend_addr_0  <= m0_HADDR;
            pend_write_0 <= m0_HWRITE;
            pend_size_0  <= m0_HSIZE;
        end else if (issue && !grant) begin
            pend_0       <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_1       <= 1'b0;
            pend_addr_1  <= '0;
            pend_write_1 <= 1'b0;
            pend_size_1  <= 3'b000;
        end else if (cap_1) begin
            pend_1       <= 1'b1;
            pend_addr_1  <= m1_HADDR;
            pend_write_1 <= m1_HWRITE;
            pend_size_1  <= m1_HSIZE;
        end else if (issue && grant) begin
            pend_1       <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid   <= 1'b0;
            dp_owner   <= 1'b0;
            last_addr  <= '0;
            last_write <= 1'b0;
            last_size  <= 3'b000;
        end else if (issue) begin
            dp_valid   <= 1'b1;
            dp_owner   <= grant;
            last_addr  <= sel_addr;
            last_write <= sel_write;
            last_size  <= sel_size;
        end else if (S_HREADYOUT) begin
            dp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Scoreboard bench for ahb_mem_arbiter: directed master stimulus, a zero/variable-wait memory slave model,
// and a monitor that checks every slave address phase and data phase against a queue of expected transfers.
module tb_ahb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [31:0] m0_HADDR, m1_HADDR;
    logic [1:0]  m0_HTRANS, m1_HTRANS;
    logic        m0_HWRITE, m1_HWRITE;
    logic [2:0]  m0_HSIZE, m1_HSIZE;
    logic [31:0] m0_HWDATA, m1_HWDATA;
    logic        m0_HREADY, m1_HREADY;
    logic [31:0] m0_HRDATA, m1_HRDATA;
    logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic        slave_ready;

    ahb_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE), .m0_HSIZE(m0_HSIZE),
        .m0_HWDATA(m0_HWDATA), .m0_HREADY(m0_HREADY), .m0_HRDATA(m0_HRDATA),
        .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE), .m1_HSIZE(m1_HSIZE),
        .m1_HWDATA(m1_HWDATA), .m1_HREADY(m1_HREADY), .m1_HRDATA(m1_HRDATA),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
    );

    // Memory slave: word i resets to 0xA5A5_0000 | i, byte lanes honoured on writes.
    logic [31:0] mem [256];
    logic        sl_dp, sl_write;
    logic [31:0] sl_addr;
    logic [2:0]  sl_size;

    assign S_HREADYOUT = slave_ready;
    assign S_HRDATA    = mem[sl_addr[9:2]];

    function automatic logic [3:0] lanes(input logic [1:0] a, input logic [2:0] sz);
        case (sz)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | i;
            sl_dp    <= 1'b0;
            sl_write <= 1'b0;
            sl_addr  <= '0;
            sl_size  <= 3'd0;
        end else begin
            if (sl_dp && sl_write && S_HREADYOUT)
                for (int b = 0; b < 4; b++)
                    if (lanes(sl_addr[1:0], sl_size)[b]) mem[sl_addr[9:2]][8*b +: 8] <= S_HWDATA[8*b +: 8];
            if (S_HREADY) begin
                sl_dp <= S_HSEL && S_HTRANS[1];
                if (S_HSEL && S_HTRANS[1]) begin
                    sl_addr  <= S_HADDR;
                    sl_write <= S_HWRITE;
                    sl_size  <= S_HSIZE;
                end
            end
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        exp_t e;
        e.addr = a; e.write = w; e.size = s; e.data = d;
        expq.push_back(e);
    endtask

    // Monitor: retire the previous data phase first, then take any new address phase.
    logic mon_dp = 1'b0;
    exp_t mon_cur;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            mon_dp = 1'b0;
        end else begin
            if (mon_dp && S_HREADYOUT) begin
                if (mon_cur.write) begin
                    check("wdata", S_HWDATA, mon_cur.data);
                end else begin
                    check("m0 rdata", m0_HRDATA, mon_cur.data);
                    check("m1 rdata", m1_HRDATA, mon_cur.data);
                end
                mon_dp = 1'b0;
            end
            if (S_HSEL && S_HREADYOUT) begin
                check("issue htrans", {30'd0, S_HTRANS}, {30'd0, NSEQ});
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected issue: got addr %h, expected no transfer (t=%0t)", S_HADDR, $time);
                end else begin
                    mon_cur = expq.pop_front();
                    check("issue addr", S_HADDR, mon_cur.addr);
                    check("issue write", {31'd0, S_HWRITE}, {31'd0, mon_cur.write});
                    check("issue size", {29'd0, S_HSIZE}, {29'd0, mon_cur.size});
                    mon_dp = 1'b1;
                end
            end
        end
    end

    task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        m0_HTRANS = t; m0_HADDR = a; m0_HWRITE = w; m0_HSIZE = s; m0_HWDATA = d;
    endtask

    task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        m1_HTRANS = t; m1_HADDR = a; m1_HWRITE = w; m1_HSIZE = s; m1_HWDATA = d;
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    initial begin
        int  k0, k1;
        logic r0, r1;
        int  budget;

        drv0(IDLE, 0, 0, 0, 0);
        drv1(IDLE, 0, 0, 0, 0);
        slave_ready = 1'b1;
        repeat (2) @(posedge HCLK);
        mid();
        check("rst S_HSEL", {31'd0, S_HSEL}, 0);
        check("rst S_HTRANS", {30'd0, S_HTRANS}, 0);
        check("rst S_HADDR", S_HADDR, 0);
        check("rst S_HWRITE", {31'd0, S_HWRITE}, 0);
        check("rst S_HSIZE", {29'd0, S_HSIZE}, 0);
        check("rst m0_HREADY", {31'd0, m0_HREADY}, 1);
        check("rst m1_HREADY", {31'd0, m1_HREADY}, 1);
        cyc();
        HRESETn = 1'b1;
        cyc();

        // Contention: M0 write 0x0 wins, M1 read 0x4 replays from its pending slot.
        drv0(NSEQ, 32'h0, 1, 3'd2, 0);
        drv1(NSEQ, 32'h4, 0, 3'd2, 0);
        push(32'h0, 1, 3'd2, 32'h1111_1111);
        push(32'h4, 0, 3'd2, 32'hA5A5_0001);
        mid();
        check("cont t S_HADDR", S_HADDR, 32'h0);
        check("cont t m1_HREADY", {31'd0, m1_HREADY}, 1);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 32'h1111_1111);
        drv1(IDLE, 0, 0, 3'd2, 0);
        mid();
        check("cont t+1 S_HADDR", S_HADDR, 32'h4);
        check("cont t+1 m1_HREADY", {31'd0, m1_HREADY}, 0);
        check("cont t+1 m0_HREADY", {31'd0, m0_HREADY}, 1);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 0);
        mid();
        check("cont t+2 m1_HREADY", {31'd0, m1_HREADY}, 1);

        // Uncontended write then read-back on M0.
        cyc();
        drv0(NSEQ, 32'h10, 1, 3'd2, 0);
        push(32'h10, 1, 3'd2, 32'hDEAD_BEEF);
        mid();
        check("uncont wr m0_HREADY", {31'd0, m0_HREADY}, 1);
        cyc();
        drv0(NSEQ, 32'h10, 0, 3'd2, 32'hDEAD_BEEF);
        push(32'h10, 0, 3'd2, 32'hDEAD_BEEF);
        mid();
        check("uncont rd m0_HREADY", {31'd0, m0_HREADY}, 1);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 0);
        mid();
        check("uncont rd dp m0_HREADY", {31'd0, m0_HREADY}, 1);

        // Lone M1 read so both policies start the next contention from master 0.
        cyc();
        drv1(NSEQ, 32'h8, 0, 3'd2, 0);
        push(32'h8, 0, 3'd2, 32'hA5A5_0002);
        cyc();
        drv1(IDLE, 0, 0, 3'd2, 0);
        cyc();

        // Both masters stream four reads each.
`ifdef AHB_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            push(32'h100 + 4*k, 0, 3'd2, 32'hA5A5_0040 + k);
            push(32'h200 + 4*k, 0, 3'd2, 32'hA5A5_0080 + k);
        end
`else
        for (int k = 0; k < 4; k++) push(32'h100 + 4*k, 0, 3'd2, 32'hA5A5_0040 + k);
        for (int k = 0; k < 4; k++) push(32'h200 + 4*k, 0, 3'd2, 32'hA5A5_0080 + k);
`endif
        k0 = 0;
        k1 = 0;
        drv0(NSEQ, 32'h100, 0, 3'd2, 0);
        drv1(NSEQ, 32'h200, 0, 3'd2, 0);
        for (int c = 0; c < 40 && !(k0 == 4 && k1 == 4); c++) begin
            mid();
            r0 = m0_HREADY;
            r1 = m1_HREADY;
`ifdef AHB_ARB_ROUND_ROBIN_EN
            if (c == 2) check("arb c2 m1_HREADY", {31'd0, r1}, 1);
`else
            if (c == 2) check("arb c2 m1_HREADY", {31'd0, r1}, 0);
`endif
            cyc();
            if (r0 && k0 < 4) k0++;
            if (r1 && k1 < 4) k1++;
            if (k0 < 4) drv0(NSEQ, 32'h100 + 4*k0, 0, 3'd2, 0);
            else        drv0(IDLE, 0, 0, 3'd2, 0);
            if (k1 < 4) drv1(NSEQ, 32'h200 + 4*k1, 0, 3'd2, 0);
            else        drv1(IDLE, 0, 0, 3'd2, 0);
        end
        check("arb m0 count", k0, 4);
        check("arb m1 count", k1, 4);
        cyc();
        cyc();

        // Slave stall during M0 write data phase while M1 requests.
        drv0(NSEQ, 32'h20, 1, 3'd2, 0);
        push(32'h20, 1, 3'd2, 32'h2222_2222);
        push(32'h24, 0, 3'd2, 32'hA5A5_0009);
        mid();
        check("stall s0 m0_HREADY", {31'd0, m0_HREADY}, 1);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 32'h2222_2222);
        drv1(NSEQ, 32'h24, 0, 3'd2, 0);
        slave_ready = 1'b0;
        mid();
        check("stall s1 m0_HREADY", {31'd0, m0_HREADY}, 0);
        check("stall s1 m1_HREADY", {31'd0, m1_HREADY}, 1);
        check("stall s1 S_HSEL", {31'd0, S_HSEL}, 0);
        cyc();
        drv1(IDLE, 0, 0, 3'd2, 0);
        mid();
        check("stall s2 m0_HREADY", {31'd0, m0_HREADY}, 0);
        check("stall s2 m1_HREADY", {31'd0, m1_HREADY}, 0);
        check("stall s2 S_HSEL", {31'd0, S_HSEL}, 0);
        cyc();
        slave_ready = 1'b1;
        mid();
        check("stall s3 m0_HREADY", {31'd0, m0_HREADY}, 1);
        check("stall s3 m1_HREADY", {31'd0, m1_HREADY}, 0);
        check("stall s3 S_HSEL", {31'd0, S_HSEL}, 1);
        check("stall s3 S_HADDR", S_HADDR, 32'h24);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 0);
        mid();
        check("stall s4 m1_HREADY", {31'd0, m1_HREADY}, 1);

        // Byte write from M1 loses to M0 and is replayed with its size and data.
        cyc();
        drv0(NSEQ, 32'h10, 0, 3'd2, 0);
        drv1(NSEQ, 32'h3, 1, 3'd0, 0);
        push(32'h10, 0, 3'd2, 32'hDEAD_BEEF);
        push(32'h3, 1, 3'd0, 32'hAB00_0000);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 0);
        drv1(IDLE, 0, 0, 3'd0, 32'hAB00_0000);
        mid();
        check("byte S_HSIZE", {29'd0, S_HSIZE}, 0);
        check("byte S_HADDR", S_HADDR, 32'h3);
        check("byte m1_HREADY", {31'd0, m1_HREADY}, 0);
        cyc();
        mid();
        check("byte S_HWDATA", S_HWDATA, 32'hAB00_0000);
        cyc();
        drv1(IDLE, 0, 0, 3'd0, 0);
        drv0(NSEQ, 32'h0, 0, 3'd2, 0);
        push(32'h0, 0, 3'd2, 32'hAB11_1111);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 0);
        cyc();
        drv1(NSEQ, 32'h8, 0, 3'd2, 0);
        push(32'h8, 0, 3'd2, 32'hA5A5_0002);
        cyc();
        drv1(IDLE, 0, 0, 3'd2, 0);
        cyc();

        // Reset while M1 is pending and M0's data phase is open.
        drv0(NSEQ, 32'h30, 0, 3'd2, 0);
        drv1(NSEQ, 32'h34, 0, 3'd2, 0);
        push(32'h30, 0, 3'd2, 32'hA5A5_000C);
        cyc();
        drv0(IDLE, 0, 0, 3'd2, 0);
        drv1(IDLE, 0, 0, 3'd2, 0);
        check("rstmid pre m1_HREADY", {31'd0, m1_HREADY}, 0);
        #1;
        HRESETn = 1'b0;
        mid();
        check("rstmid m0_HREADY", {31'd0, m0_HREADY}, 1);
        check("rstmid m1_HREADY", {31'd0, m1_HREADY}, 1);
        check("rstmid S_HSEL", {31'd0, S_HSEL}, 0);
        check("rstmid S_HTRANS", {30'd0, S_HTRANS}, 0);
        cyc();
        HRESETn = 1'b1;
        mid();
        check("rstmid post S_HSEL", {31'd0, S_HSEL}, 0);
        cyc();
        drv1(NSEQ, 32'h38, 0, 3'd2, 0);
        push(32'h38, 0, 3'd2, 32'hA5A5_000E);
        mid();
        check("rstmid fresh m1_HREADY", {31'd0, m1_HREADY}, 1);
        check("rstmid fresh S_HADDR", S_HADDR, 32'h38);
        cyc();
        drv1(IDLE, 0, 0, 3'd2, 0);

        budget = 0;
        while ((expq.size() != 0 || mon_dp) && budget < 20) begin
            cyc();
            budget++;
        end
        mid();
        check("queue drained", expq.size(), 0);
        check("data phase retired", {31'd0, mon_dp}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
